// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard and stall sequencer for a five-stage MIPS pipeline.
// Each cycle it decides whether the PC and each pipeline register loads, holds,
// or is cleared to a bubble. It handles load-use hazards, taken-branch flushes
// and data-memory wait states.
//
// Optional feature: define PIPE_HAZARD_CTRL_PERF_EN to build the saturating
// stall_cycles / flush_count performance counters. When it is undefined both
// outputs are tied to zero and no counter flops exist.
//
// Outputs are Mealy: a hazard stalls in the same cycle it is detected.

module pipe_hazard_ctrl #(
  parameter int unsigned WIDTH      = 32,
  // Bubble cycles per load-use hazard; legal range 1..3.
  parameter int unsigned LOAD_STALL = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_write,
  output logic             mem_wb_write,
  output logic [WIDTH-1:0] stall_cycles,
  output logic [WIDTH-1:0] flush_count
);

  typedef enum logic [1:0] {
    StRun       = 2'd0,
    StLoadStall = 2'd1,
    StMemWait   = 2'd2
  } state_e;

  // Control vector order: {pc_write, if_id_write, if_id_flush, id_ex_flush,
  //                        ex_mem_write, mem_wb_write}
  localparam logic [5:0] CtlRun    = 6'b110011;
  localparam logic [5:0] CtlFlush  = 6'b111011;
  localparam logic [5:0] CtlStall  = 6'b000111;
  localparam logic [5:0] CtlFreeze = 6'b000000;

  // The detection cycle is the first bubble, so the counter covers the rest.
  localparam logic [1:0] CntInit    = 2'(LOAD_STALL - 1);
  localparam bit         MultiStall = (LOAD_STALL > 1);

  state_e     state_q, state_d;
  state_e     ret_q, ret_d;
  state_e     eff_state;
  logic [1:0] cnt_q, cnt_d;
  logic [5:0] ctl;
  logic       lu;
  logic       mw;

  assign lu = ex_mem_read && (ex_rd != 5'd0) &&
              ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
  assign mw = dmem_req && !dmem_ready;

  // if_id_flush dominates if_id_write at the pipeline register itself.
  assign {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write, mem_wb_write} = ctl;

  // Next-state and Mealy control decode.
  always_comb begin
    ctl     = CtlRun;
    state_d = state_q;
    ret_d   = ret_q;
    cnt_d   = cnt_q;

    // On the completing memory cycle the pipe is no longer frozen: behave
    // exactly as the state the wait interrupted would, including its
    // transition. A resumed load stall therefore spends this cycle as one of
    // its bubbles and only stays in LOAD_STALL if cycles remain.
    eff_state = state_q;
    if (state_q == StMemWait && dmem_ready) begin
      eff_state = ret_q;
    end

    unique case (eff_state)
      StRun: begin
        if (mw) begin
          ctl     = CtlFreeze;
          ret_d   = StRun;
          state_d = StMemWait;
        end else if (lu) begin
          ctl = CtlStall;
          if (MultiStall) begin
            cnt_d   = CntInit;
            state_d = StLoadStall;
          end else begin
            state_d = StRun;
          end
        end else if (branch_taken) begin
          ctl     = CtlFlush;
          state_d = StRun;
        end else begin
          ctl     = CtlRun;
          state_d = StRun;
        end
      end
      StLoadStall: begin
        if (mw) begin
          // cnt is held so the stall resumes where it left off.
          ctl     = CtlFreeze;
          ret_d   = StLoadStall;
          state_d = StMemWait;
        end else begin
          ctl     = CtlStall;
          cnt_d   = cnt_q - 2'd1;
          state_d = (cnt_q == 2'd1) ? StRun : StLoadStall;
        end
      end
      StMemWait: begin
        // Only reached while dmem_ready is low.
        ctl = CtlFreeze;
      end
      default: begin
        ctl     = CtlRun;
        state_d = StRun;
      end
    endcase

    // During reset every register loads so the pipe clears through its own reset.
    if (reset) begin
      ctl = CtlRun;
    end
  end

  // FSM state, return state and stall counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StRun;
      ret_q   <= StRun;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [WIDTH-1:0] stall_cycles_q;
  logic [WIDTH-1:0] flush_count_q;

  // Saturating perf counters: cycles with the PC held, and IF/ID flushes.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (!pc_write && (stall_cycles_q != {WIDTH{1'b1}})) begin
        stall_cycles_q <= stall_cycles_q + WIDTH'(1);
      end
      if (if_id_flush && (flush_count_q != {WIDTH{1'b1}})) begin
        flush_count_q <= flush_count_q + WIDTH'(1);
      end
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl. Three instances (LOAD_STALL = 1, 2, 3) share
// one stimulus stream; each cycle the expected control vector for every
// instance is queued, and a negedge monitor pops and compares it together with
// the perf counters.

module tb_pipe_hazard_ctrl;

  localparam int unsigned W = 16;

  // {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write, mem_wb_write}
  localparam logic [5:0] ER = 6'b110011;  // run
  localparam logic [5:0] EF = 6'b111011;  // branch flush
  localparam logic [5:0] ES = 6'b000111;  // load-use bubble
  localparam logic [5:0] EZ = 6'b000000;  // memory freeze

  typedef struct packed {
    logic       rst;
    logic [5:0] o;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic [4:0] id_rs = 5'd1;
  logic [4:0] id_rt = 5'd2;
  logic       id_uses_rt = 1'b1;
  logic       ex_mem_read = 1'b0;
  logic [4:0] ex_rd = 5'd0;
  logic       branch_taken = 1'b0;
  logic       dmem_req = 1'b0;
  logic       dmem_ready = 1'b0;

  logic [5:0]   o1, o2, o3;
  logic [W-1:0] sc1, sc2, sc3, fc1, fc2, fc3;

  pipe_hazard_ctrl #(.WIDTH(W), .LOAD_STALL(1)) u_dut1 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .branch_taken(branch_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write(o1[5]), .if_id_write(o1[4]), .if_id_flush(o1[3]), .id_ex_flush(o1[2]),
    .ex_mem_write(o1[1]), .mem_wb_write(o1[0]), .stall_cycles(sc1), .flush_count(fc1)
  );

  pipe_hazard_ctrl #(.WIDTH(W), .LOAD_STALL(2)) u_dut2 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .branch_taken(branch_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write(o2[5]), .if_id_write(o2[4]), .if_id_flush(o2[3]), .id_ex_flush(o2[2]),
    .ex_mem_write(o2[1]), .mem_wb_write(o2[0]), .stall_cycles(sc2), .flush_count(fc2)
  );

  pipe_hazard_ctrl #(.WIDTH(W), .LOAD_STALL(3)) u_dut3 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .branch_taken(branch_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write(o3[5]), .if_id_write(o3[4]), .if_id_flush(o3[3]), .id_ex_flush(o3[2]),
    .ex_mem_write(o3[1]), .mem_wb_write(o3[0]), .stall_cycles(sc3), .flush_count(fc3)
  );

  exp_t q1[$];
  exp_t q2[$];
  exp_t q3[$];

  int          n_checks = 0;
  int          n_pass   = 0;
  int unsigned m_stall[3];
  int unsigned m_flush[3];
  bit          m_known[3];
  int          m_cyc[3];

  // Drive one cycle of inputs and queue the expected control for each instance.
  task automatic step(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                      input logic urt, input logic mr, input logic [4:0] rd,
                      input logic br, input logic req, input logic rdy,
                      input logic [5:0] e1, input logic [5:0] e2, input logic [5:0] e3);
    @(posedge clk);
    #1;
    reset        = rst;
    id_rs        = rs;
    id_rt        = rt;
    id_uses_rt   = urt;
    ex_mem_read  = mr;
    ex_rd        = rd;
    branch_taken = br;
    dmem_req     = req;
    dmem_ready   = rdy;
    q1.push_back('{rst: rst, o: e1});
    q2.push_back('{rst: rst, o: e2});
    q3.push_back('{rst: rst, o: e3});
  endtask

  task automatic check_dut(input int idx, input exp_t e, input logic [5:0] act,
                           input logic [W-1:0] sc, input logic [W-1:0] fc);
    logic [W-1:0] exp_sc;
    logic [W-1:0] exp_fc;
    n_checks++;
    if (act === e.o) n_pass++;
    else $display("FAIL ctl ls%0d cyc%0d: got %b want %b", idx + 1, m_cyc[idx], act, e.o);
    if (m_known[idx]) begin
`ifdef PIPE_HAZARD_CTRL_PERF_EN
      exp_sc = W'(m_stall[idx]);
      exp_fc = W'(m_flush[idx]);
`else
      exp_sc = '0;
      exp_fc = '0;
`endif
      n_checks++;
      if (sc === exp_sc) n_pass++;
      else $display("FAIL stall_cycles ls%0d cyc%0d: got %0d want %0d",
                    idx + 1, m_cyc[idx], sc, exp_sc);
      n_checks++;
      if (fc === exp_fc) n_pass++;
      else $display("FAIL flush_count ls%0d cyc%0d: got %0d want %0d",
                    idx + 1, m_cyc[idx], fc, exp_fc);
    end
    // Counter model: register value seen next cycle.
    if (e.rst) begin
      m_known[idx] = 1'b1;
      m_stall[idx] = 0;
      m_flush[idx] = 0;
    end else if (m_known[idx]) begin
      if (!e.o[5]) m_stall[idx]++;
      if (e.o[3])  m_flush[idx]++;
    end
    m_cyc[idx]++;
  endtask

  // Monitor: one expected entry per instance per cycle.
  always @(negedge clk) begin
    if (q1.size() > 0) check_dut(0, q1.pop_front(), o1, sc1, fc1);
    if (q2.size() > 0) check_dut(1, q2.pop_front(), o2, sc2, fc2);
    if (q3.size() > 0) check_dut(2, q3.pop_front(), o3, sc3, fc3);
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      m_stall[i] = 0;
      m_flush[i] = 0;
      m_known[i] = 1'b0;
      m_cyc[i]   = 0;
    end
    //   rst   rs     rt     urt   mr    rd     br    req   rdy   ls1 ls2 ls3
    // Reset
    step(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, ER, ER, ER);
    step(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, ER, ER, ER);
    step(1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, ER, ER, ER);
    // Load-use on rs
    step(1'b0, 5'd8, 5'd2, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, ES, ES, ES);
    step(1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, ER, ES, ES);
    step(1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, ER, ER, ES);
    step(1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, ER, ER, ER);
    // Load-use on rt
    step(1'b0, 5'd1, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, ES, ES, ES);
    step(1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, ER, ES, ES);
    step(1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, ER, ER, ES);
    step(1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, ER, ER, ER);
    // rt match but rt not a source: no stall
    step(1'b0, 5'd1, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, ER, ER, ER);
    // Register zero never hazards
    step(1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, ER, ER, ER);
    // Taken branch
    step(1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, EF, EF, EF);
    step(1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, ER, ER, ER);
    // Branch with load-use: ignored; re-presented branch flushes only in RUN
    step(1'b0, 5'd8, 5'd2, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, ES, ES, ES);
    step(1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, EF, ES, ES);
    step(1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, ER, ER, ES);
    step(1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, ER, ER, ER);
    // Memory wait: three frozen cycles, released on the fourth
    step(1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, EZ, EZ, EZ);
    step(1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, EZ, EZ, EZ);
    step(1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, EZ, EZ, EZ);
    step(1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, ER, ER, ER);
    step(1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, ER, ER, ER);
    // Load-use present during the wait: stall starts on the ready cycle
    step(1'b0, 5'd8, 5'd2, 1'b1, 1'b1, 5'd8, 1'b0, 1'b1, 1'b0, EZ, EZ, EZ);
    step(1'b0, 5'd8, 5'd2, 1'b1, 1'b1, 5'd8, 1'b0, 1'b1, 1'b0, EZ, EZ, EZ);
    step(1'b0, 5'd8, 5'd2, 1'b1, 1'b1, 5'd8, 1'b0, 1'b1, 1'b1, ES, ES, ES);
    step(1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, ER, ES, ES);
    step(1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, ER, ER, ES);
    step(1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, ER, ER, ER);
    // Wait inside LOAD_STALL: count held, resumed after ready
    step(1'b0, 5'd8, 5'd2, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, ES, ES, ES);
    step(1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, EZ, EZ, EZ);
    step(1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, ER, ES, ES);
    step(1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, ER, ER, ES);
    step(1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, ER, ER, ER);
    // Reset after one LOAD_STALL cycle: next cycle is a clean RUN
    step(1'b0, 5'd8, 5'd2, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, ES, ES, ES);
    step(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, ER, ER, ER);
    step(1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, ER, ER, ER);
    // Reset during MEM_WAIT
    step(1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, EZ, EZ, EZ);
    step(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, ER, ER, ER);
    step(1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, ER, ER, ER);
    step(1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, EF, EF, EF);
    step(1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, ER, ER, ER);

    // Let the monitor drain, bounded.
    for (int i = 0; i < 10 && (q1.size() + q2.size() + q3.size()) > 0; i++) begin
      @(negedge clk);
    end
    @(posedge clk);
    if ((q1.size() + q2.size() + q3.size()) > 0) begin
      n_checks++;
      $display("FAIL drain: %0d entries left, want 0", q1.size() + q2.size() + q3.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
